program_loader: RTL

Front-panel program loader for the 8-bit CPU. While `load_req` is high it holds the CPU sequencer idle, takes program bytes from the dedicated input pins over a four-phase handshake, and writes them to consecutive RAM addresses through the shared 8-bit bus and the MAR/RAM control strobes. It sits beside the control block in the top level: the two strobe sets are ANDed (all strobes active-low), and the bus gets the loader's driver only while `bus_oe` is high.

---
 rtl/loader_pkg.sv | 16 +
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader_sync2.sv | 23 ++
 rtl/program_loader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the front-panel program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ADR,
        DAT,
        WR,
        FINISH
    } state_t;

    localparam logic [2:0] STROBE_IDLE = 3'b111;
    localparam logic [7:0] BUS_ZERO    = 8'h00;

endpackage

// File: rtl/program_loader_if.sv
// Byte handshake and shared-bus signals between the loader and the CPU top level.
interface program_loader_if;

    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ack;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       nLma;
    logic       nLmd;
    logic       nLr;

    modport master (
        input  data_in, data_valid,
        output data_ack, bus_out, bus_oe, nLma, nLmd, nLr
    );

    modport slave (
        output data_in, data_valid,
        input  data_ack, bus_out, bus_oe, nLma, nLmd, nLr
    );

endinterface

// File: rtl/program_loader_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Front-panel program loader: holds the CPU idle and writes handshaked bytes
// to consecutive RAM addresses through the shared bus and MAR/RAM strobes.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    program_loader_if.master  lb,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    logic [1:0]  sync_q;
    logic        req_s;
    logic        valid_s;

    state_t      state;
    logic [7:0]  hold_q;
    logic        req_seen_low;
    logic        ack_q;
    logic [7:0]  bus_q;
    logic        oe_q;
    logic [2:0]  strobe_q;    // {nLma, nLmd, nLr}
    logic        busy_q;
    logic        done_q;

    sync2 #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({load_req, lb.data_valid}),
        .q     (sync_q)
    );

    assign req_s   = sync_q[1];
    assign valid_s = sync_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            hold_q       <= '0;
            req_seen_low <= 1'b1;
            ack_q        <= 1'b0;
            bus_q        <= BUS_ZERO;
            oe_q         <= 1'b0;
            strobe_q     <= STROBE_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            bus_q    <= BUS_ZERO;
            oe_q     <= 1'b0;
            strobe_q <= STROBE_IDLE;
            done_q   <= 1'b0;

            // Acknowledge drops once the strobe is seen low, whatever the state.
            if (ack_q && !valid_s)
                ack_q <= 1'b0;

            case (state)
                IDLE: begin
                    // After a full-program finish, require load_req to go low first.
                    if (!req_s) begin
                        req_seen_low <= 1'b1;
                    end else if (req_seen_low) begin
                        state        <= WAIT;
                        addr         <= '0;
                        req_seen_low <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!req_s) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                    end else if (valid_s && !ack_q) begin
                        hold_q      <= lb.data_in;
                        state       <= ADR;
                        bus_q       <= 8'(addr);
                        oe_q        <= 1'b1;
                        strobe_q[2] <= 1'b0;
                    end
                end
                ADR: begin
                    state       <= DAT;
                    bus_q       <= hold_q;
                    oe_q        <= 1'b1;
                    strobe_q[1] <= 1'b0;
                end
                DAT: begin
                    state       <= WR;
                    strobe_q[0] <= 1'b0;
                end
                WR: begin
                    ack_q <= 1'b1;
                    if (addr == LAST_ADDR) begin
                        state  <= FINISH;
                        done_q <= 1'b1;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= WAIT;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign lb.data_ack = ack_q;
    assign lb.bus_out  = bus_q;
    assign lb.bus_oe   = oe_q;
    assign lb.nLma     = strobe_q[2];
    assign lb.nLmd     = strobe_q[1];
    assign lb.nLr      = strobe_q[0];
    assign busy        = busy_q;
    assign cpu_hold    = busy_q;
    assign done        = done_q;

endmodule
